// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding the decode pipeline register.
//
// Owns the fetch PC and issues in-order requests to instruction memory over a
// req/gnt + rvalid bus. Returned instructions are buffered together with
// their PC and PC+4 in a DEPTH-entry FIFO and offered to decode through a
// valid/ready handshake. A redirect flushes the FIFO and drops every response
// still in flight.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   init_pc                 PC loaded while in reset (low two bits cleared)
//   imem_req/imem_addr      fetch request and byte address (pc[IADDR-1:0])
//   imem_gnt                request accepted this cycle
//   imem_rvalid/imem_rdata  in-order response, at least one cycle after grant
//   redirect/redirect_pc    flush and restart fetch at redirect_pc
//   out_valid/out_ready     decode handshake
//   out_instr/out_pc/out_inc_pc  head instruction, its PC and PC+4
//
// Optional feature (compile-time macro FETCH_QUEUE_BYPASS_EN): a non-discarded
// response arriving while the FIFO is empty is presented on out_* in the same
// cycle and is not written to storage if decode takes it immediately.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IADDR = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] init_pc,
  output logic             imem_req,
  output logic [IADDR-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inc_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      CAP        = (CW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             run_q, run_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    outs_q, outs_d;
  logic [CW-1:0]    disc_q, disc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    tag_wr_q, tag_wr_d;
  logic [AW-1:0]    tag_rd_q, tag_rd_d;

  logic [WIDTH-1:0] fifo_instr_q [DEPTH];
  logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [WIDTH-1:0] fifo_inc_q   [DEPTH];
  logic [WIDTH-1:0] tag_pc_q     [DEPTH];

  logic             grant;
  logic             fifo_empty;
  logic             rsp_keep;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] rsp_inc_pc;
  logic [CW:0]      credit_used;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic             bypass;
`endif

  // Issue: a request may go out only while requests in flight plus buffered
  // entries leave room, so every kept response has a FIFO slot waiting.
  // run_q holds requests off until the first edge after reset release.
  always_comb begin : issue_comb
    credit_used = {1'b0, outs_q} + {1'b0, cnt_q};
    imem_req    = run_q && !redirect && (credit_used < CAP);
    imem_addr   = pc_q[IADDR-1:0];
    grant       = imem_req && imem_gnt;
  end

  // Response tagging and decode-side outputs. The tag queue pops on every
  // response, discarded or not, so it stays aligned with the memory order.
  always_comb begin : output_comb
    rsp_pc     = tag_pc_q[tag_rd_q];
    rsp_inc_pc = rsp_pc + PC_STEP;
    fifo_empty = (cnt_q == '0);
    rsp_keep   = imem_rvalid && !redirect && (disc_q == '0);
    out_instr  = fifo_instr_q[rd_ptr_q];
    out_pc     = fifo_pc_q[rd_ptr_q];
    out_inc_pc = fifo_inc_q[rd_ptr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = fifo_empty && rsp_keep;
    out_valid = !fifo_empty || bypass;
    if (bypass) begin
      out_instr  = imem_rdata;
      out_pc     = rsp_pc;
      out_inc_pc = rsp_inc_pc;
    end
    pop  = !fifo_empty && out_ready && !redirect;
    push = rsp_keep && !(bypass && out_ready);
`else
    out_valid = !fifo_empty;
    pop       = out_valid && out_ready && !redirect;
    push      = rsp_keep;
`endif
  end

  always_comb begin : next_state_comb
    pc_d     = pc_q;
    run_d    = 1'b1;
    outs_d   = outs_q + CW'(grant) - CW'(imem_rvalid);
    disc_d   = disc_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    tag_wr_d = tag_wr_q + AW'(grant);
    tag_rd_d = tag_rd_q + AW'(imem_rvalid);

    if (redirect) begin
      // Everything still outstanding after this cycle's response (which is
      // itself dropped) must be thrown away when it returns.
      pc_d     = redirect_pc & ALIGN_MASK;
      disc_d   = outs_q - CW'(imem_rvalid);
      cnt_d    = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (grant) begin
        pc_d = pc_q + PC_STEP;
      end
      if (imem_rvalid && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : state_ff
    if (!reset_n) begin
      pc_q     <= init_pc & ALIGN_MASK;
      run_q    <= 1'b0;
      cnt_q    <= '0;
      outs_q   <= '0;
      disc_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      outs_q   <= outs_d;
      disc_q   <= disc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while in reset.
  always_ff @(posedge clk or negedge reset_n) begin : storage_ff
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
        fifo_inc_q[i]   <= '0;
        tag_pc_q[i]     <= '0;
      end
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= rsp_pc;
        fifo_inc_q[wr_ptr_q]   <= rsp_inc_pc;
      end
      if (grant) begin
        tag_pc_q[tag_wr_q] <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-level model of fetch/deliver order checked
// every cycle, plus literal expectations for latency, ordering and reset.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] init_pc = 32'h100;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_inc_pc;

  fetch_queue #(.WIDTH(32), .IADDR(10), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .init_pc(init_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_inc_pc(out_inc_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;

  // Memory environment: responses scheduled in grant order.
  int          mem_due[$];
  logic [9:0]  mem_adr[$];

  // Model: PCs fetched but not answered, PCs buffered for decode.
  logic [31:0] infl[$];
  logic [31:0] expq[$];
  int          disc_m = 0;
  logic [31:0] exp_pc = '0;
  bit          run_m = 1'b0;

  // Observations for the literal checks.
  int          dut_grants = 0;
  logic [31:0] dut_pops[$];
  bit          s_valid, s_req;
  logic [9:0]  s_addr;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {12'hBEE, a, a};
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    if (i < dut_pops.size()) return dut_pops[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    expq.delete();
    mem_due.delete();
    mem_adr.delete();
    disc_m = 0;
    run_m  = 1'b0;
    exp_pc = {init_pc[31:2], 2'b00};
  endtask

  // One clock cycle: drive memory response, compare DUT against model,
  // then advance the model by what happened at the clock edge.
  task automatic cycle();
    bit er, ev, rv, rd, gr_m, pop_m;
    logic [31:0] rpc, h, p;
    @(negedge clk);
    rv = 1'b0;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      rv = 1'b1;
      imem_rdata = mem_word(mem_adr[0]);
      void'(mem_due.pop_front());
      void'(mem_adr.pop_front());
    end else begin
      imem_rdata = 32'hDEAD_BEEF;
    end
    imem_rvalid = rv;
    #1;
    rd  = redirect;
    rpc = redirect_pc;
    er = run_m && !rd && ((infl.size() + expq.size()) < D);
    chk("imem_req", 32'(imem_req), 32'(er));
    if (er) chk("imem_addr", 32'(imem_addr), 32'(exp_pc[9:0]));
    ev = (expq.size() > 0);
    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      h = expq[0];
      chk("out_pc", out_pc, h);
      chk("out_instr", out_instr, mem_word(h[9:0]));
      chk("out_inc_pc", out_inc_pc, h + 32'd4);
    end
    s_valid = out_valid;
    s_req   = imem_req;
    s_addr  = imem_addr;
    if (imem_req && imem_gnt) begin
      dut_grants++;
      mem_due.push_back(cyc + lat);
      mem_adr.push_back(imem_addr);
    end
    if (out_valid && out_ready && !rd) dut_pops.push_back(out_pc);
    gr_m  = er && imem_gnt;
    pop_m = ev && out_ready;
    @(posedge clk);
    #1;
    cyc++;
    run_m = 1'b1;
    if (rd) begin
      if (rv && infl.size() > 0) void'(infl.pop_front());
      expq.delete();
      disc_m = infl.size();
      exp_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop_m) void'(expq.pop_front());
      if (rv && infl.size() > 0) begin
        p = infl.pop_front();
        if (disc_m > 0) disc_m--;
        else expq.push_back(p);
      end
      if (gr_m) begin
        infl.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    cycle();
    redirect    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"},   32'(imem_req),  32'd0);
    chk({tag, "_out_valid"},  32'(out_valid), 32'd0);
    chk({tag, "_out_pc"},     out_pc,         32'd0);
    chk({tag, "_out_instr"},  out_instr,      32'd0);
    chk({tag, "_out_inc_pc"}, out_inc_pc,     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    bit found;

    // Power-on reset.
    #1 reset_n = 1'b0;
    #10;
    check_reset_outputs("reset");
    model_reset();
    @(posedge clk); #2; reset_n = 1'b1;

    // Streaming from init_pc with 1-cycle memory.
    first = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (s_valid && first < 0) first = k;
    end
    chk("reset_to_valid_latency", 32'(first), 32'd3);
    chk("stream_pop_count", 32'(dut_pops.size()), 32'd9);
    chk("stream_first_pc", pop_at(0), 32'h100);
    chk("stream_ninth_pc", pop_at(8), 32'h120);

    // Back-pressure from an empty queue: exactly DEPTH requests, then stall.
    out_ready = 1'b0;
    do_redirect(32'h300);
    dut_grants = 0;
    repeat (10) cycle();
    chk("stall_grant_count", 32'(dut_grants), 32'd4);
    chk("stall_req_low", 32'(s_req), 32'd0);
    out_ready = 1'b1;
    dut_pops.delete();
    repeat (12) cycle();
    chk("release_pop_count", 32'(dut_pops.size()), 32'd12);
    chk("release_first_pc", pop_at(0), 32'h300);
    chk("release_last_pc", pop_at(11), 32'h32C);

    // Grant withheld: address must hold until accepted.
    imem_gnt = 1'b0;
    repeat (3) cycle();
    imem_gnt = 1'b1;
    repeat (4) cycle();

    // 3-cycle memory with three requests in flight, then redirect.
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (infl.size() == 3) found = 1'b1;
    end
    chk("three_inflight_reached", 32'(found), 32'd1);
    do_redirect(32'h200);
    dut_pops.delete();
    repeat (14) cycle();
    chk("lat3_redirect_first_pc", pop_at(0), 32'h200);
    chk("lat3_redirect_second_pc", pop_at(1), 32'h204);

    // Redirect coincident with a response and a decode handshake.
    lat = 1;
    repeat (6) cycle();
    do_redirect(32'h200);
    dut_pops.delete();
    first = -1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (s_valid && first < 0) first = k;
    end
    chk("redirect_to_valid_latency", 32'(first), 32'd3);
    chk("coincident_first_pc", pop_at(0), 32'h200);

    // Unaligned redirect target.
    do_redirect(32'h203);
    cycle();
    chk("unaligned_req", 32'(s_req), 32'd1);
    chk("unaligned_addr", 32'(s_addr), 32'h200);
    repeat (4) cycle();

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFB);
    dut_pops.delete();
    repeat (10) cycle();
    chk("wrap_pc0", pop_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", pop_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", pop_at(2), 32'h0000_0000);
    chk("wrap_pc3", pop_at(3), 32'h0000_0004);

    // Reset asserted mid-stream with two requests outstanding.
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (infl.size() == 2) found = 1'b1;
    end
    chk("two_inflight_reached", 32'(found), 32'd1);
    #2;
    reset_n     = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    init_pc = 32'h502;
    model_reset();
    lat = 1;
    repeat (2) @(posedge clk);
    #2; reset_n = 1'b1;
    dut_pops.delete();
    first = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_valid && first < 0) first = k;
    end
    chk("post_reset_latency", 32'(first), 32'd3);
    chk("post_reset_first_pc", pop_at(0), 32'h500);
    chk("post_reset_second_pc", pop_at(1), 32'h504);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the decode pipeline register.
- Owns the PC and issues in-order requests to the instruction memory over a request/grant, response-valid bus.
- Buffers returned instructions with their PC and PC+4 in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes everything in flight.

Parameters:
- WIDTH, 32, data/PC width.
- IADDR, 10, instruction-memory byte-address width.
- DEPTH, 4, FIFO entries; also the cap on requests outstanding plus buffered (power of two, ≥2).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- init_pc  input  WIDTH  PC loaded on reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  IADDR  fetch byte address, equal to pc[IADDR-1:0].
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata  input  WIDTH  response instruction.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  WIDTH  new fetch PC.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_instr  output  WIDTH  head instruction.
- out_pc  output  WIDTH  head PC.
- out_inc_pc  output  WIDTH  head PC+4.

Behaviour:
- Reset (async, reset_n=0):
  - pc=init_pc with bits[1:0] forced to 0.
  - FIFO empty; outstanding=0; discard=0.
  - imem_req=0; out_valid=0; out_instr/out_pc/out_inc_pc=0.
  - Deassertion takes effect at the next clk edge.
- Request issue:
  - imem_req=1 when !redirect && (outstanding + count) < DEPTH.
  - Request accepted on imem_req && imem_gnt: pc += 4 (wraps modulo 2^WIDTH); outstanding++.
  - imem_addr is stable while imem_req=1 and !imem_gnt.
- Response:
  - On imem_rvalid: outstanding--.
  - If discard>0, the response is dropped and discard--.
  - Otherwise {imem_rdata, tag_pc, tag_pc+4} is written to the FIFO tail. tag_pc is the PC of that request, held in an internal DEPTH-entry in-order PC queue.
  - The FIFO is never full on a non-discarded response, guaranteed by the issue credit.
- Output:
  - out_* = FIFO head, combinational from storage.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle keep count unchanged.
  - A pop from a full FIFO frees the credit next cycle, not combinationally.
- Redirect (registered effect):
  - FIFO count→0; out_valid=0 next cycle.
  - pc ← {redirect_pc[WIDTH-1:2], 2'b00}.
  - discard ← outstanding minus any response arriving in this same cycle. A response coincident with redirect is dropped.
  - Grant coincident with redirect cannot occur, because imem_req=0 while redirect=1.
  - Redirect takes priority over pop and push.
  - Fetching resumes the cycle after redirect deasserts.
- Latency:
  - From redirect deassertion: request in cycle N+1.
  - With 1-cycle memory, out_valid at N+3: grant N+1, rvalid N+2, FIFO registered N+3.
  - Steady state: one instruction per cycle when imem_gnt=1 always and the memory is 1-cycle.
- Back-pressure: out_ready=0 stalls issue once outstanding+count=DEPTH. Nothing is lost or duplicated.
- Counters: count and outstanding are $clog2(DEPTH)+1 bits; discard has the same width.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When the FIFO is empty and imem_rvalid arrives non-discarded, the response drives out_* combinationally with out_valid=1 in the same cycle.
  - If out_ready=1 it is consumed without being written.
  - Latency from redirect becomes N+2.
- Undefined: all output goes through FIFO storage, per the timing above.

Test Plan:
- Reset with init_pc=0x100, 1-cycle memory, out_ready=1 → requests 0x100,0x104,0x108…; out_pc/out_instr match, out_inc_pc=out_pc+4, one per cycle after the initial 3-cycle latency.
- out_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req=0. Release → 4 buffered entries in order, then streaming resumes with no gaps or duplicates.
- Memory latency 3 cycles with 3 outstanding, redirect to 0x200 → 3 in-flight responses dropped; first delivered out_pc=0x200.
- Redirect coincident with imem_rvalid and with out_valid&&out_ready → response dropped, no pop visible, out_valid=0 next cycle, next delivery at 0x200.
- redirect_pc=0x203 → first fetch address 0x200. PC near 2^WIDTH-4 → wraps to 0.
- Assert reset_n=0 mid-stream with 2 outstanding → outputs zero immediately. Post-reset stale responses are not accepted; the bench holds rvalid low during reset.
